// File: rtl/spi_pkg.sv
// Shared SPI definitions: receiver FSM states and the default word width,
// common to the SPI transmitter and receiver.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic {
        SPI_RX_IDLE,
        SPI_RX_RECV
    } spi_rx_state_e;

endpackage

// File: rtl/spi_sync.sv
// N-stage flop synchronizer for one asynchronous input, with a selectable reset value.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_rx_slave.sv
// SPI slave receiver: oversamples sclk/cs/mosi, shifts in words MSB-first and
// hands them out on a valid/ready port. Define SPI_RX_FRAME_ERR_EN to report cs aborts.
module spi_rx_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    output logic              rx_frame_err,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic s_sclk, s_cs, s_mosi;
    logic sclk_d_q, sclk_rise;
    logic [1:0] rise_q, mosi_q;

    spi_rx_state_e     state_q, state_d;
    logic [DATA_W-2:0] shift_q, shift_d;
    logic [DATA_W-1:0] word;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              overrun_q, overrun_d;
    logic              frame_err_d;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk_i(clk), .rst_ni(rst), .d_i(sclk), .q_o(s_sclk)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk_i(clk), .rst_ni(rst), .d_i(cs), .q_o(s_cs)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i(clk), .rst_ni(rst), .d_i(mosi), .q_o(s_mosi)
    );

    assign sclk_rise = s_sclk & ~sclk_d_q;

    // Edge and data travel together through two extra stages, so a word lands
    // SYNC_STAGES+2 clocks after its last sclk rise is first sampled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_d_q <= 1'b0;
            rise_q   <= '0;
            mosi_q   <= '0;
        end else begin
            sclk_d_q <= s_sclk;
            rise_q   <= {rise_q[0], sclk_rise};
            mosi_q   <= {mosi_q[0], s_mosi};
        end
    end

    assign word = {shift_q, mosi_q[1]};

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~rx_ready;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            SPI_RX_IDLE: begin
                if (!s_cs) begin
                    state_d = SPI_RX_RECV;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            SPI_RX_RECV: begin
                if (s_cs) begin
                    state_d     = SPI_RX_IDLE;
                    cnt_d       = '0;
                    frame_err_d = (cnt_q != '0);
                end else if (rise_q[1]) begin
                    shift_d = word[DATA_W-2:0];
                    if (cnt_q == LAST_BIT) begin
                        cnt_d      = '0;
                        rx_data_d  = word;
                        rx_valid_d = 1'b1;
                        overrun_d  = rx_valid_q & ~rx_ready;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SPI_RX_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef SPI_RX_FRAME_ERR_EN
    logic frame_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_frame_err = frame_err_q;
`else
    logic unused_frame_err;

    assign unused_frame_err = frame_err_d;
    assign rx_frame_err     = 1'b0;
`endif

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = overrun_q;
    assign busy       = (state_q == SPI_RX_RECV);

endmodule

// File: tb/tb_spi_rx_slave.sv
// Self-checking bench for spi_rx_slave: an event-schedule model of the SPI link
// compared with the DUT every cycle, plus directed literal checks.
module tb_spi_rx_slave;

    localparam int DW   = 8;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sclk = 1'b0;
    logic cs = 1'b1;
    logic mosi = 1'b0;
    logic rx_ready = 1'b0;
    logic [DW-1:0] rx_data;
    logic rx_valid, rx_overrun, rx_frame_err, busy;

    int checks = 0;
    int errors = 0;
    bit randReady = 1'b0;

    spi_rx_slave #(.DATA_W(DW), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: the driver books what must happen at which clock edge; this block
    // replays the bookings and applies the valid/ready handshake rules.
    int edgeNo = 0;
    logic [DW-1:0] compAt[int];
    bit errAt[int];
    bit busyAt[int];
    logic [DW-1:0] mData = '0;
    logic mValid = 1'b0, mOverrun = 1'b0, mFrameErr = 1'b0, mBusy = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mData     <= '0;
            mValid    <= 1'b0;
            mOverrun  <= 1'b0;
            mFrameErr <= 1'b0;
            mBusy     <= 1'b0;
        end else begin
            edgeNo    <= edgeNo + 1;
            mOverrun  <= compAt.exists(edgeNo + 1) && mValid && !rx_ready;
            mFrameErr <= errAt.exists(edgeNo + 1);
            if (compAt.exists(edgeNo + 1)) begin
                mData  <= compAt[edgeNo + 1];
                mValid <= 1'b1;
            end else if (mValid && rx_ready) begin
                mValid <= 1'b0;
            end
            if (busyAt.exists(edgeNo + 1)) mBusy <= busyAt[edgeNo + 1];
        end
    end

    int bitsInFrame = 0;
    logic [DW-1:0] curWord = '0;
    int lastCapture = 0;
    int riseEdge = 0;
    logic [DW-1:0] capturedWord = '0;
    logic [DW-1:0] gotWords[$];
    int ovCnt = 0, feCnt = 0;
    bit busyWatch = 1'b0, busyLowSeen = 1'b0;
    logic prevValid = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compareLoop();
        forever begin
            @(negedge clk);
            #1;
            checkOutput("rx_valid", 32'(rx_valid), 32'(mValid));
            checkOutput("rx_data", 32'(rx_data), 32'(mData));
            checkOutput("rx_overrun", 32'(rx_overrun), 32'(mOverrun));
            checkOutput("rx_frame_err", 32'(rx_frame_err), 32'(mFrameErr));
            checkOutput("busy", 32'(busy), 32'(mBusy));
            if (rx_valid && !prevValid) begin
                riseEdge     = edgeNo;
                capturedWord = rx_data;
            end
            if (rx_valid && rx_ready) gotWords.push_back(rx_data);
            if (rx_overrun) ovCnt++;
            if (rx_frame_err) feCnt++;
            if (busyWatch && !busy) busyLowSeen = 1'b1;
            prevValid = rx_valid;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (randReady) rx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic csLow();
        tick();
        cs = 1'b0;
        busyAt[edgeNo + 1 + SYNC] = 1'b1;
        bitsInFrame = 0;
        curWord = '0;
        ticks(4);
    endtask

    task automatic csHigh();
        int d;
        tick();
        cs = 1'b1;
        d = edgeNo + 1;
        busyAt[d + SYNC] = 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
        if (bitsInFrame % DW != 0) errAt[d + SYNC] = 1'b1;
`endif
        ticks(6);
    endtask

    task automatic sendBit(input logic b, input int hi, input int lo);
        int c;
        tick();
        mosi = b;
        ticks(lo);
        sclk = 1'b1;
        c = edgeNo + 1;
        bitsInFrame++;
        curWord = {curWord[DW-2:0], b};
        if (bitsInFrame % DW == 0) begin
            compAt[c + LAT] = curWord;
            lastCapture = c;
        end
        ticks(hi);
        sclk = 1'b0;
    endtask

    task automatic sendWord(input logic [DW-1:0] v, input bit rnd);
        for (int i = DW - 1; i >= 0; i--) begin
            if (rnd) sendBit(v[i], $urandom_range(3, 6), $urandom_range(3, 6));
            else     sendBit(v[i], 4, 3);
        end
    endtask

    task automatic idleNoise(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            mosi = 1'($urandom_range(0, 1));
            sclk = ~sclk;
            ticks(2);
        end
        tick();
        sclk = 1'b0;
    endtask

    task automatic applyStimulus(input int frames);
        int nWords, extra;
        logic [DW-1:0] v;
        for (int f = 0; f < frames; f++) begin
            nWords = $urandom_range(0, 3);
            extra  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DW - 1) : 0;
            csLow();
            for (int w = 0; w < nWords; w++) begin
                v = DW'($urandom);
                sendWord(v, 1'b1);
            end
            for (int b = 0; b < extra; b++)
                sendBit(1'($urandom_range(0, 1)), $urandom_range(3, 6), $urandom_range(3, 6));
            csHigh();
            if ($urandom_range(0, 3) == 0) idleNoise(4);
        end
    endtask

    initial begin
        fork
            compareLoop();
        join_none

        ticks(3);
        rst = 1'b1;
        ticks(4);
        #1;
        checkOutput("reset rx_valid", 32'(rx_valid), 32'h0);
        checkOutput("reset rx_data", 32'(rx_data), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);

        // Single byte with its latency
        rx_ready = 1'b1;
        ovCnt = 0;
        feCnt = 0;
        csLow();
        sendWord(8'hAA, 1'b0);
        csHigh();
        ticks(6);
        checkOutput("single data", 32'(capturedWord), 32'hAA);
        checkOutput("single latency", 32'(riseEdge - lastCapture), 32'(LAT));
        checkOutput("single overrun", 32'(ovCnt), 32'd0);
        checkOutput("single frame_err", 32'(feCnt), 32'd0);

        // Two-byte frame, busy held throughout
        gotWords.delete();
        busyLowSeen = 1'b0;
        csLow();
        busyWatch = 1'b1;
        sendWord(8'h5A, 1'b0);
        sendWord(8'hC3, 1'b0);
        busyWatch = 1'b0;
        csHigh();
        ticks(6);
        checkOutput("two count", 32'(gotWords.size()), 32'd2);
        if (gotWords.size() == 2) begin
            checkOutput("two word0", 32'(gotWords[0]), 32'h5A);
            checkOutput("two word1", 32'(gotWords[1]), 32'hC3);
        end
        checkOutput("two busy drop", 32'(busyLowSeen), 32'd0);

        // Overrun
        rx_ready = 1'b0;
        ovCnt = 0;
        csLow();
        sendWord(8'h11, 1'b0);
        sendWord(8'h22, 1'b0);
        csHigh();
        ticks(6);
        #1;
        checkOutput("overrun pulses", 32'(ovCnt), 32'd1);
        checkOutput("overrun data", 32'(rx_data), 32'h22);
        checkOutput("overrun valid", 32'(rx_valid), 32'd1);
        tick();
        rx_ready = 1'b1;
        ticks(3);
        #1;
        checkOutput("overrun drained", 32'(rx_valid), 32'd0);

        // Frame abort after 3 bits
        feCnt = 0;
        csLow();
        sendBit(1'b1, 4, 3);
        sendBit(1'b0, 4, 3);
        sendBit(1'b1, 4, 3);
        csHigh();
        ticks(6);
        #1;
`ifdef SPI_RX_FRAME_ERR_EN
        checkOutput("abort frame_err", 32'(feCnt), 32'd1);
`else
        checkOutput("abort frame_err", 32'(feCnt), 32'd0);
`endif
        checkOutput("abort valid", 32'(rx_valid), 32'd0);
        checkOutput("abort data", 32'(rx_data), 32'h22);

        // Idle noise with cs high
        idleNoise(10);
        ticks(6);
        #1;
        checkOutput("idle busy", 32'(busy), 32'd0);
        checkOutput("idle valid", 32'(rx_valid), 32'd0);
        checkOutput("idle data", 32'(rx_data), 32'h22);

        // Reset after 5 bits, then a clean frame
        csLow();
        for (int i = 0; i < 5; i++) sendBit(1'b1, 4, 3);
        tick();
        rst  = 1'b0;
        cs   = 1'b1;
        sclk = 1'b0;
        compAt.delete();
        errAt.delete();
        busyAt.delete();
        ticks(3);
        #1;
        checkOutput("midreset data", 32'(rx_data), 32'h0);
        checkOutput("midreset valid", 32'(rx_valid), 32'd0);
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset overrun", 32'(rx_overrun), 32'd0);
        checkOutput("midreset frame_err", 32'(rx_frame_err), 32'd0);
        tick();
        rst = 1'b1;
        ticks(4);
        gotWords.delete();
        csLow();
        sendWord(8'h3C, 1'b0);
        csHigh();
        ticks(6);
        #1;
        checkOutput("post-reset count", 32'(gotWords.size()), 32'd1);
        checkOutput("post-reset data", 32'(rx_data), 32'h3C);

        // Randomized frames against the model
        randReady = 1'b1;
        applyStimulus(25);
        randReady = 1'b0;
        tick();
        rx_ready = 1'b1;
        ticks(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_rx_slave.md
# spi_rx_slave

SPI slave receiver forming the far end of the team's SPI transmit link. It oversamples the incoming `sclk`, `cs` and `mosi` pins in the system `clk` domain. It shifts in bits MSB-first on each rising `sclk` edge while `cs` is low, and presents each completed byte on a valid/ready interface to downstream logic.

## Interface
- `DATA_W`, 8: bits per word.
- `SYNC_STAGES`, 2: flops in each input synchronizer (legal values are 2 or more).
- `clk`  input  1  system clock; all logic is on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `sclk`  input  1  SPI clock from the master; asynchronous to `clk`.
- `cs`  input  1  chip select, active-low; asynchronous.
- `mosi`  input  1  serial data from the master; asynchronous.
- `rx_data`  output  DATA_W  last completed word.
- `rx_valid`  output  1  `rx_data` holds an unconsumed word.
- `rx_ready`  input  1  consumer accepts the word.
- `rx_overrun`  output  1  one-cycle pulse: a word completed while `rx_valid` was still high.
- `rx_frame_err`  output  1  one-cycle pulse: `cs` rose mid-word (only with the macro).
- `busy`  output  1  high while in RECV.

## Operation
- `sclk`, `cs` and `mosi` each pass through an identical `SYNC_STAGES` synchronizer, so the three signals stay mutually aligned.
- A registered copy of synchronized `sclk` provides edge detection: `sclk_rise = s_sclk & ~s_sclk_d`.
- **FSM**
  - IDLE to RECV when synchronized `cs` is 0. This transition clears the shift register and sets `bit_cnt` to 0.
  - RECV to IDLE when synchronized `cs` is 1, whatever `bit_cnt` holds.
  - The default state is IDLE.
- **In RECV, on `sclk_rise`**
  - `shift <= {shift[DATA_W-2:0], s_mosi}`.
  - `bit_cnt` increments.
  - At `bit_cnt == DATA_W-1` the counter wraps to 0. `{shift[DATA_W-2:0], s_mosi}` is loaded into `rx_data` and `rx_valid` is set.
  - The FSM stays in RECV, so back-to-back words in one `cs` frame are received without gaps.
- **`sclk` edges while in IDLE** are ignored.
- **`rx_valid` handshake**
  - Cleared on any cycle with `rx_valid & rx_ready`.
  - If a word completes in the same cycle, set takes priority over clear: `rx_valid` stays 1 and the new word is loaded.
- **Overrun**
  - Occurs when a word completes while `rx_valid` is 1 and `rx_ready` is 0.
  - The new word overwrites `rx_data`, `rx_valid` stays 1, and `rx_overrun` pulses for one cycle.
- **Partial word at `cs` rise** (`bit_cnt != 0`): the partial bits are discarded and `rx_data` is unchanged.

## Timing
- **Reset values:** `rx_data` = 0, `rx_valid` = 0, `rx_overrun` = 0, `rx_frame_err` = 0, `busy` = 0, FSM = IDLE, `bit_cnt` = 0, all synchronizer flops = 0 (the `cs` synchronizer resets to 1).
- **Latency:** `rx_valid` rises exactly `SYNC_STAGES`+2 `clk` edges after the edge at which the first synchronizer flop captures the final `sclk` rise.
- **`sclk` constraints:** high and low phases must each last at least `SYNC_STAGES`+1 `clk` periods.
- **`mosi` constraint:** must be stable at the pin from `SYNC_STAGES` `clk` periods before each `sclk` rise until the same time after it.
- **`busy`** follows the FSM state, one cycle after the synchronized `cs` change.
- **Reset asserted mid-word:** the block returns immediately to the reset values listed above. The next word is received only after `cs` is seen high and then low again.

## Configuration
- Macro: `SPI_RX_FRAME_ERR_EN`.
- **Defined:** RECV to IDLE with `bit_cnt != 0` pulses `rx_frame_err` for one cycle, registered on the transition cycle.
- **Undefined:** `rx_frame_err` is tied to 0, and the partial word is still discarded silently.

## Structure
- **Package `spi_pkg`:** FSM state typedef (`SPI_RX_IDLE`, `SPI_RX_RECV`) and the default `DATA_W` constant, shared with the transmitter.
- **Sub-module `spi_sync`:** parameterised N-stage synchronizer with a parameterised reset value, instantiated three times.

## Test plan
- **Single byte:** `cs` low, 8 `sclk` periods of 8 `clk` each carrying 0xAA MSB-first, `cs` high, `rx_ready` = 1 -> one `rx_valid` pulse with `rx_data` = 0xAA at the specified latency; `rx_overrun` and `rx_frame_err` stay 0.
- **Two-byte frame:** 0x5A then 0xC3 in one `cs` frame, consumer ready -> two words 0x5A then 0xC3; `busy` stays high throughout the frame.
- **Overrun:** two bytes 0x11 then 0x22 with `rx_ready` = 0 -> `rx_overrun` pulses once at the second completion; `rx_data` = 0x22 and `rx_valid` = 1 until `rx_ready`.
- **Frame abort:** `cs` rises after 3 bits -> with the macro, one `rx_frame_err` pulse; in both builds no `rx_valid` and `rx_data` unchanged.
- **Idle noise:** `sclk` toggles with `cs` high -> no state change and no outputs.
- **Reset mid-word:** `rst` low after 5 bits, then released, then a full 0x3C frame -> all reset values present, then `rx_data` = 0x3C with no stray bits.
